// File: rtl/sd_sector_sequencer_if.sv
// sd_sector_sequencer_if: control, SD controller and write-port signals of the sector sequencer
interface sd_sector_sequencer_if #(
    parameter int ADDR_W = 20
);
    logic              start;
    logic [31:0]       start_sector;
    logic [15:0]       sector_count;
    logic              busy;
    logic              done;
    logic              error;
    logic              sd_ready;
    logic              sd_rd;
    logic [31:0]       sd_address;
    logic              sd_byte_available;
    logic [7:0]        sd_dout;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        input  start, start_sector, sector_count, sd_ready, sd_byte_available, sd_dout,
        output busy, done, error, sd_rd, sd_address, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, start_sector, sector_count, sd_ready, sd_byte_available, sd_dout,
        input  busy, done, error, sd_rd, sd_address, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/sd_sector_sequencer.sv
// sd_sector_sequencer: reads a run of 512-byte SD sectors and streams every byte to a write port
// Define SD_SEQ_BYTE_ADDR_EN for SDSC byte addressing (sd_address = sector << 9)
module sd_sector_sequencer #(
    parameter int ADDR_W         = 20,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TO_W           = 26
) (
    input logic                   CLK,
    input logic                   reset,
    sd_sector_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, ACK, DATA, DRAIN, DONE, ERR} state_t;

    state_t          state;
    logic [31:0]     cur_sector;
    logic [15:0]     remaining;
    logic [8:0]      byte_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            byte_prev;
    logic            byte_rise;
    logic            waiting;
    logic            timed_out;
    logic [31:0]     blk_addr;

    assign byte_rise = bus.sd_byte_available & ~byte_prev;
    assign waiting   = state inside {ISSUE, ACK, DATA, DRAIN};
    assign timed_out = waiting & ~byte_rise & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`ifdef SD_SEQ_BYTE_ADDR_EN
    assign blk_addr  = {cur_sector[22:0], 9'd0};
`else
    assign blk_addr  = cur_sector;
`endif

    // Sequencer FSM with registered outputs; timeout counter restarts on each state change or byte strobe
    always_ff @(posedge CLK) begin
        if (reset) begin
            state          <= IDLE;
            cur_sector     <= '0;
            remaining      <= '0;
            byte_cnt       <= '0;
            to_cnt         <= '0;
            byte_prev      <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
            bus.sd_rd      <= 1'b0;
            bus.sd_address <= '0;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
        end else begin
            byte_prev <= bus.sd_byte_available;
            bus.done  <= 1'b0;
            bus.sd_rd <= 1'b0;
            bus.wr_en <= 1'b0;
            to_cnt    <= byte_rise ? '0 : to_cnt + TO_W'(1);
            if (bus.wr_en)
                bus.wr_addr <= bus.wr_addr + ADDR_W'(1);
            if (timed_out) begin
                bus.error <= 1'b1;
                bus.busy  <= 1'b0;
                state     <= ERR;
            end
            case (state)
                IDLE: if (bus.start) begin
                    cur_sector  <= bus.start_sector;
                    remaining   <= bus.sector_count;
                    byte_cnt    <= '0;
                    to_cnt      <= '0;
                    bus.wr_addr <= '0;
                    bus.error   <= 1'b0;
                    bus.busy    <= 1'b1;
                    state       <= (bus.sector_count == 16'd0) ? DONE : ISSUE;
                end
                ISSUE: if (bus.sd_ready) begin
                    bus.sd_address <= blk_addr;
                    bus.sd_rd      <= 1'b1;
                    to_cnt         <= '0;
                    state          <= ACK;
                end
                ACK: if (!bus.sd_ready) begin
                    to_cnt <= '0;
                    state  <= DATA;
                end
                DATA: if (byte_rise) begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_data <= bus.sd_dout;
                    byte_cnt    <= byte_cnt + 9'd1;
                    if (byte_cnt == 9'd511)
                        state <= DRAIN;
                end
                DRAIN: if (bus.sd_ready) begin
                    cur_sector <= cur_sector + 32'd1;
                    remaining  <= remaining - 16'd1;
                    to_cnt     <= '0;
                    state      <= (remaining == 16'd1) ? DONE : ISSUE;
                end
                DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_sector_sequencer.sv
// tb_sd_sector_sequencer: directed scoreboard bench for sd_sector_sequencer with a simple card model
module tb_sd_sector_sequencer;
    localparam int AW = 11;
    localparam int TO = 1000;

    logic          CLK      = 1'b0;
    logic          reset    = 1'b1;
    int            checks   = 0;
    int            errors   = 0;
    int            rd_cnt   = 0;
    int            done_cnt = 0;
    logic          prev_rd  = 1'b0;
    logic          saw_rd   = 1'b0;
    logic [31:0]   exp_rd[$];
    logic [AW-1:0] exp_wa[$];
    logic [7:0]    exp_wd[$];
    logic [AW-1:0] wa;

    sd_sector_sequencer_if #(.ADDR_W(AW)) bus ();

    sd_sector_sequencer #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO), .TO_W(26)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] blk(input logic [31:0] s);
`ifdef SD_SEQ_BYTE_ADDR_EN
        return s << 9;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        saw_rd = bus.sd_rd;
        if (bus.sd_rd) begin
            rd_cnt++;
            chk("rd_gap", prev_rd, 1'b0);
            chk("rd_expected", exp_rd.size() != 0, 1'b1);
            if (exp_rd.size() != 0)
                chk("sd_address", bus.sd_address, exp_rd.pop_front());
        end
        prev_rd = bus.sd_rd;
        if (bus.wr_en) begin
            chk("wr_expected", exp_wa.size() != 0, 1'b1);
            if (exp_wa.size() != 0) begin
                chk("wr_addr", bus.wr_addr, exp_wa.pop_front());
                chk("wr_data", bus.wr_data, exp_wd.pop_front());
            end
        end
        if (bus.done)
            done_cnt++;
    endtask

    task automatic serve(input logic [31:0] sec, input int nbytes, output int lat);
        lat = 0;
        exp_rd.push_back(blk(sec));
        do begin
            step();
            lat++;
        end while (!saw_rd && lat < 3000);
        chk("rd_arrived", saw_rd, 1'b1);
        bus.sd_ready = 1'b0;
        step();
        step();
        for (int i = 0; i < nbytes; i++) begin
            bus.sd_dout           = 8'(i);
            bus.sd_byte_available = 1'b1;
            exp_wa.push_back(wa);
            exp_wd.push_back(8'(i));
            wa++;
            step();
            bus.sd_byte_available = 1'b0;
            step();
        end
        if (nbytes == 512) begin
            step();
            step();
            bus.sd_ready = 1'b1;
        end
    endtask

    task automatic start_pulse(input logic [31:0] sec, input logic [15:0] cnt);
        wa               = '0;
        bus.start_sector = sec;
        bus.sector_count = cnt;
        bus.start        = 1'b1;
        step();
        bus.start        = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int r0, input int nrd);
        int n = 0;
        while (!bus.done && n < 50) begin
            step();
            n++;
        end
        chk("done_pulse", bus.done, 1'b1);
        chk("busy_at_done", bus.busy, 1'b0);
        repeat (3) step();
        chk("done_count", done_cnt - d0, 1);
        chk("rd_count", rd_cnt - r0, nrd);
        chk("wr_left", exp_wa.size(), 0);
        chk("rd_left", exp_rd.size(), 0);
    endtask

    task automatic run(input logic [31:0] sec, input logic [15:0] cnt);
        int lat, d0, r0;
        d0 = done_cnt;
        r0 = rd_cnt;
        start_pulse(sec, cnt);
        chk("busy_on_start", bus.busy, 1'b1);
        for (int s = 0; s < int'(cnt); s++) begin
            serve(sec + 32'(s), 512, lat);
            chk("rd_latency", lat, (s == 0) ? 1 : 2);
        end
        wait_done(d0, r0, int'(cnt));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_error", bus.error, 1'b0);
        chk("rst_sd_rd", bus.sd_rd, 1'b0);
        chk("rst_sd_address", bus.sd_address, 32'd0);
        chk("rst_wr_en", bus.wr_en, 1'b0);
        chk("rst_wr_addr", bus.wr_addr, '0);
        chk("rst_wr_data", bus.wr_data, 8'd0);
    endtask

    initial begin
        int lat, d0, r0, n;
        bus.start             = 1'b0;
        bus.start_sector      = '0;
        bus.sector_count      = '0;
        bus.sd_ready          = 1'b0;
        bus.sd_byte_available = 1'b0;
        bus.sd_dout           = '0;
        repeat (3) step();
        chk_reset_outputs();
        reset        = 1'b0;
        bus.sd_ready = 1'b1;
        step();

        run(32'h10, 16'd1);
        run(32'd100, 16'd3);
        run(32'hFFFF_FFFE, 16'd5);

        d0 = done_cnt;
        r0 = rd_cnt;
        bus.sd_ready = 1'b0;
        start_pulse(32'd7, 16'd1);
        for (int i = 0; i < 900; i++) begin
            if (i == 100) begin
                bus.start_sector = 32'd50;
                bus.sector_count = 16'd5;
                bus.start        = 1'b1;
            end
            step();
            bus.start = 1'b0;
        end
        chk("rd_before_ready", rd_cnt - r0, 0);
        chk("busy_while_init", bus.busy, 1'b1);
        bus.sd_ready = 1'b1;
        serve(32'd7, 512, lat);
        chk("rd_latency_init", lat, 1);
        wait_done(d0, r0, 1);

        d0 = done_cnt;
        start_pulse(32'd20, 16'd1);
        serve(32'd20, 200, lat);
        n = 2;
        while (!bus.error && n < 1200) begin
            step();
            n++;
        end
        chk("timeout_cycle", n, 1001);
        chk("timeout_error", bus.error, 1'b1);
        chk("timeout_busy", bus.busy, 1'b0);
        step();
        chk("error_sticky", bus.error, 1'b1);
        chk("timeout_no_done", done_cnt - d0, 0);
        chk("timeout_wr_left", exp_wa.size(), 0);

        bus.sd_ready = 1'b1;
        d0 = done_cnt;
        r0 = rd_cnt;
        start_pulse(32'd3, 16'd0);
        chk("start_clears_error", bus.error, 1'b0);
        chk("zero_busy", bus.busy, 1'b1);
        chk("zero_no_done_yet", bus.done, 1'b0);
        step();
        chk("zero_done_2cyc", bus.done, 1'b1);
        wait_done(d0, r0, 0);

        run(32'h44, 16'd1);

        bus.sd_ready = 1'b1;
        start_pulse(32'd5, 16'd2);
        serve(32'd5, 300, lat);
        reset = 1'b1;
        step();
        chk_reset_outputs();
        reset = 1'b0;
        bus.sd_ready = 1'b1;
        step();
        chk("post_reset_busy", bus.busy, 1'b0);
        chk("post_reset_wr_left", exp_wa.size(), 0);
        run(32'h33, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
